// File: rtl/trap_ctrl_pkg.sv
// Shared types and constants for the machine-mode trap/mret sequencer.
package trap_ctrl_pkg;

    typedef logic [11:0] csr_addr_t;

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        WR_MEPC,
        WR_MCAUSE,
        WR_MSTATUS,
        REDIRECT
    } trap_state_t;

    localparam csr_addr_t CSR_MSTATUS = 12'h300;
    localparam csr_addr_t CSR_MTVEC   = 12'h305;
    localparam csr_addr_t CSR_MEPC    = 12'h341;
    localparam csr_addr_t CSR_MCAUSE  = 12'h342;

    localparam int unsigned CAUSE_MISALIGNED_FETCH = 0;
    localparam int unsigned CAUSE_ILLEGAL_INSTR    = 2;
    localparam int unsigned CAUSE_BREAKPOINT       = 3;
    localparam int unsigned CAUSE_ECALL_M          = 11;

    localparam int unsigned MSTATUS_MIE    = 3;
    localparam int unsigned MSTATUS_MPIE   = 7;
    localparam int unsigned MSTATUS_MPP_LO = 11;
    localparam int unsigned MSTATUS_MPP_HI = 12;

endpackage

// File: rtl/trap_ctrl_mstatus_next.sv
// Next mstatus value for trap entry (stack MIE into MPIE, enter M-mode)
// or for mret (pop MPIE into MIE, drop to U-mode).
module mstatus_next
    import trap_ctrl_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] mstatus_i,
    input  logic            is_mret_i,
    output logic [XLEN-1:0] mstatus_o
);

    // Only MIE, MPIE and MPP move; every other bit passes through.
    always_comb begin
        mstatus_o = mstatus_i;
        if (is_mret_i) begin
            mstatus_o[MSTATUS_MIE]                   = mstatus_i[MSTATUS_MPIE];
            mstatus_o[MSTATUS_MPIE]                  = 1'b1;
            mstatus_o[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b00;
        end else begin
            mstatus_o[MSTATUS_MPIE]                  = mstatus_i[MSTATUS_MIE];
            mstatus_o[MSTATUS_MIE]                   = 1'b0;
            mstatus_o[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Trap / mret sequencer: flushes the pipe, writes mepc/mcause/mstatus
// through a single CSR port one per cycle, then redirects fetch.
//
// state      | meaning
// IDLE       | waiting for a request, trap_ready high
// FLUSH      | kill younger in-flight instructions
// WR_MEPC    | write aligned trapping PC to mepc (trap only)
// WR_MCAUSE  | write cause code to mcause (trap only)
// WR_MSTATUS | write updated interrupt-enable stack / privilege
// REDIRECT   | steer fetch to mtvec (trap) or mepc (mret)
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int          XLEN        = 64,
    parameter int unsigned ECALL_CAUSE = CAUSE_ECALL_M
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            trap_valid,
    output logic            trap_ready,
    input  logic            trap_is_exception,
    input  logic            trap_is_ecall,
    input  logic            trap_is_mret,
    input  logic [3:0]      trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] mstatus_i,
    input  logic [XLEN-1:0] mtvec_i,
    input  logic [XLEN-1:0] mepc_i,
    output logic            csr_wvalid,
    output csr_addr_t       csr_wa,
    output logic [XLEN-1:0] csr_wd,
    output logic            flush,
    output logic            busy,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    typedef logic [XLEN-1:0] word_t;

    localparam word_t ALIGN_MASK = ~word_t'(3);

    trap_state_t state_q, state_d;
    logic        is_mret_q, is_mret_d;
    logic        is_ecall_q, is_ecall_d;
    logic [3:0]  cause_q, cause_d;
    word_t       pc_q, pc_d;
    word_t       mstatus_upd;
    logic        accept;
    logic        req_trap;

    assign trap_ready = (state_q == IDLE);
    assign accept     = trap_valid && trap_ready;
    // Exception/ecall wins over a simultaneous mret.
    assign req_trap   = trap_is_exception || trap_is_ecall;

    mstatus_next #(
        .XLEN(XLEN)
    ) u_mstatus_next (
        .mstatus_i(mstatus_i),
        .is_mret_i(is_mret_q),
        .mstatus_o(mstatus_upd)
    );

    // State and captured request registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            is_mret_q  <= 1'b0;
            is_ecall_q <= 1'b0;
            cause_q    <= '0;
            pc_q       <= '0;
        end else begin
            state_q    <= state_d;
            is_mret_q  <= is_mret_d;
            is_ecall_q <= is_ecall_d;
            cause_q    <= cause_d;
            pc_q       <= pc_d;
        end
    end

    // Next-state and request capture; a request with no kind bit is
    // consumed without leaving IDLE.
    always_comb begin
        state_d    = state_q;
        is_mret_d  = is_mret_q;
        is_ecall_d = is_ecall_q;
        cause_d    = cause_q;
        pc_d       = pc_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    is_mret_d  = !req_trap && trap_is_mret;
                    is_ecall_d = trap_is_ecall;
                    cause_d    = trap_cause;
                    pc_d       = trap_pc;
                    if (req_trap || trap_is_mret) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH:      state_d = is_mret_q ? WR_MSTATUS : WR_MEPC;
            WR_MEPC:    state_d = WR_MCAUSE;
            WR_MCAUSE:  state_d = WR_MSTATUS;
            WR_MSTATUS: state_d = REDIRECT;
            REDIRECT:   state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // Per-state outputs; the write bus stays zero whenever it is not valid.
    always_comb begin
        flush          = 1'b0;
        busy           = (state_q != IDLE);
        csr_wvalid     = 1'b0;
        csr_wa         = '0;
        csr_wd         = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (state_q)
            FLUSH: flush = 1'b1;
            WR_MEPC: begin
                csr_wvalid = 1'b1;
                csr_wa     = CSR_MEPC;
                csr_wd     = pc_q & ALIGN_MASK;
            end
            WR_MCAUSE: begin
                csr_wvalid = 1'b1;
                csr_wa     = CSR_MCAUSE;
                csr_wd     = is_ecall_q ? word_t'(ECALL_CAUSE) : word_t'(cause_q);
            end
            WR_MSTATUS: begin
                csr_wvalid = 1'b1;
                csr_wa     = CSR_MSTATUS;
                csr_wd     = mstatus_upd;
            end
            REDIRECT: begin
                redirect_valid = 1'b1;
                redirect_pc    = is_mret_q ? mepc_i : (mtvec_i & ALIGN_MASK);
            end
            default: ;
        endcase
    end

endmodule
